// File: rtl/asic_soc_top.sv
// asic_soc_top
//   Top-level SoC shell. After reset a built-in self-test engine exercises an
//   internal single-port synchronous RAM with a two-pass pattern: P(a) is
//   written to every address and read back, then ~P(a) is written and read
//   back, where P(a) = SEED ^ a. A free-running heartbeat divider runs
//   alongside the test and does not depend on it.
//
// Ports
//   clk_25m          in   system clock (25 MHz nominal)
//   rst              in   synchronous reset, active-high
//   done             out  self-test finished; stays high until reset
//   pass             out  done and no mismatch seen
//   fail             out  set on the first mismatch; stays high until reset
//   err_cnt          out  mismatch count, saturating at 16'hFFFF
//   first_fail_addr  out  address of the first mismatch (0 if none)
//   heartbeat        out  toggles once every HB_DIV cycles
module asic_soc_top #(
    parameter int               ADDR_W       = 8,
    parameter int               DATA_W       = 32,
    parameter logic [31:0]      SEED         = 32'hA5A5_0000,
    parameter int               HB_DIV       = 12_500_000,
    parameter int               INJECT_FAULT = 0,
    parameter logic [ADDR_W-1:0] FAULT_ADDR  = '0
) (
    input  logic              clk_25m,
    input  logic              rst,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic              heartbeat
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int HB_W  = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_P,
        S_RD_P,
        S_WR_N,
        S_RD_N,
        S_DONE
    } state_t;

    // Test word for address a; inv selects the inverse-data pass.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                  input logic              inv);
        logic [DATA_W-1:0] p;
        p = DATA_W'(SEED) ^ DATA_W'(a);
        return inv ? ~p : p;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W:0]     cnt;          // one extra bit so reads can run to DEPTH
    logic [ADDR_W-1:0]   addr_c;
    logic                cnt_clr;
    logic                cnt_inc;
    logic                ram_we;
    logic                ram_re;
    logic                inv_c;
    logic                flip_c;
    logic [DATA_W-1:0]   wdata_c;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                rd_vld_p1;
    logic [DATA_W-1:0]   rd_data_p1;
    logic [ADDR_W-1:0]   rd_addr_p1;
    logic                rd_inv_p1;
    logic                mism_c;

    logic [HB_W-1:0]     hb_cnt;

    assign addr_c = cnt[ADDR_W-1:0];

    // Sequencer
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write phases end on the last address; read phases run one step past it
    // (cnt == DEPTH) so the final read's data can still be compared.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        inv_c     = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_clr   = 1'b1;
                state_nxt = S_WR_P;
            end
            S_WR_P: begin
                ram_we = 1'b1;
                if (&addr_c) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_RD_P;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_RD_P: begin
                ram_re = ~cnt[ADDR_W];
                if (cnt[ADDR_W]) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_WR_N;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_WR_N: begin
                ram_we = 1'b1;
                inv_c  = 1'b1;
                if (&addr_c) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_RD_N;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_RD_N: begin
                ram_re = ~cnt[ADDR_W];
                inv_c  = 1'b1;
                if (cnt[ADDR_W]) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + (ADDR_W + 1)'(1);
        end
    end

    // Deliberate single-bit corruption in the inverse pass, used to prove
    // the checker can see an error.
    assign flip_c  = (INJECT_FAULT != 0) && (state == S_WR_N) && (addr_c == FAULT_ADDR);
    assign wdata_c = pattern(addr_c, inv_c) ^ {{(DATA_W-1){1'b0}}, flip_c};

    // ---- stage p0 -> p1: RAM access; read data and its tags arrive next cycle
    always_ff @(posedge clk_25m) begin
        if (ram_we) begin
            mem[addr_c] <= wdata_c;
        end
        if (ram_re) begin
            rd_data_p1 <= mem[addr_c];
        end
        rd_addr_p1 <= addr_c;
        rd_inv_p1  <= inv_c;
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            rd_vld_p1 <= 1'b0;
        end else begin
            rd_vld_p1 <= ram_re;
        end
    end

    // ---- stage p1: compare against regenerated expected word
    assign mism_c = rd_vld_p1 && (rd_data_p1 != pattern(rd_addr_p1, rd_inv_p1));

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            done            <= 1'b0;
            fail            <= 1'b0;
            err_cnt         <= '0;
            first_fail_addr <= '0;
        end else begin
            if (state == S_DONE) begin
                done <= 1'b1;
            end
            if (mism_c) begin
                err_cnt <= sat_inc16(err_cnt);
                if (!fail) begin
                    fail            <= 1'b1;
                    first_fail_addr <= rd_addr_p1;
                end
            end
        end
    end

    assign pass = done & ~fail;

    // Heartbeat divider, independent of the self-test sequencer.
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            hb_cnt    <= '0;
            heartbeat <= 1'b0;
        end else if (hb_cnt == HB_W'(HB_DIV - 1)) begin
            hb_cnt    <= '0;
            heartbeat <= ~heartbeat;
        end else begin
            hb_cnt <= hb_cnt + HB_W'(1);
        end
    end

endmodule

// File: tb/tb_asic_soc_top.sv
// Directed bench for asic_soc_top: three instances (full size, fault
// injected at 8'h3C, and a 16x8 RAM) share one clock and reset.
// cyc holds the index of the last rising edge since reset release
// (edge 0 is the first one sampled with rst=0); all sampling is 1 time
// unit after a rising edge.
module tb_asic_soc_top;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = -1;

    always #20 clk = ~clk;

    logic        d_done, d_pass, d_fail, d_hb;
    logic [15:0] d_err;
    logic [7:0]  d_ffa;
    logic        f_done, f_pass, f_fail, f_hb;
    logic [15:0] f_err;
    logic [7:0]  f_ffa;
    logic        s_done, s_pass, s_fail, s_hb;
    logic [15:0] s_err;
    logic [3:0]  s_ffa;

    asic_soc_top #(.ADDR_W(8), .DATA_W(32), .HB_DIV(10)) u_dut (
        .clk_25m(clk), .rst(rst), .done(d_done), .pass(d_pass), .fail(d_fail),
        .err_cnt(d_err), .first_fail_addr(d_ffa), .heartbeat(d_hb));

    asic_soc_top #(.ADDR_W(8), .DATA_W(32), .HB_DIV(10),
                   .INJECT_FAULT(1), .FAULT_ADDR(8'h3C)) u_flt (
        .clk_25m(clk), .rst(rst), .done(f_done), .pass(f_pass), .fail(f_fail),
        .err_cnt(f_err), .first_fail_addr(f_ffa), .heartbeat(f_hb));

    asic_soc_top #(.ADDR_W(4), .DATA_W(8), .HB_DIV(10)) u_sml (
        .clk_25m(clk), .rst(rst), .done(s_done), .pass(s_pass), .fail(s_fail),
        .err_cnt(s_err), .first_fail_addr(s_ffa), .heartbeat(s_hb));

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
        cyc = cyc + n;
    endtask

    task automatic wait_until(input int k);
        if (k > cyc) wait_edges(k - cyc);
    endtask

    task automatic release_reset();
        rst = 1'b0;
        cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_edges(4096);
        checks++;
        if ({d_done, d_pass, d_fail, d_hb, d_err, d_ffa} !== 28'h0) begin
            errors++;
            $display("FAIL reset_dut: got %h want 0", {d_done, d_pass, d_fail, d_hb, d_err, d_ffa});
        end
        checks++;
        if ({f_done, f_pass, f_fail, f_hb, f_err, f_ffa} !== 28'h0) begin
            errors++;
            $display("FAIL reset_flt: got %h want 0", {f_done, f_pass, f_fail, f_hb, f_err, f_ffa});
        end
        checks++;
        if ({s_done, s_pass, s_fail, s_hb, s_err, s_ffa} !== 24'h0) begin
            errors++;
            $display("FAIL reset_sml: got %h want 0", {s_done, s_pass, s_fail, s_hb, s_err, s_ffa});
        end
        release_reset();
    endtask

    task automatic test_heartbeat();
        // toggles at edges 9, 19, 29
        int          at [6]   = '{8, 9, 18, 19, 28, 29};
        logic        want [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            wait_until(at[i]);
            checks++;
            if (d_hb !== want[i] || s_hb !== want[i]) begin
                errors++;
                $display("FAIL heartbeat@%0d: got %b/%b want %b", at[i], d_hb, s_hb, want[i]);
            end
        end
        checks++;
        if (d_done !== 1'b0) begin
            errors++;
            $display("FAIL early_done: got %b want 0", d_done);
        end
    endtask

    task automatic test_small();
        wait_until(66);
        checks++;
        if (s_done !== 1'b0) begin
            errors++;
            $display("FAIL small_done@66: got %b want 0", s_done);
        end
        wait_until(67);
        checks++;
        if (s_done !== 1'b1 || s_pass !== 1'b1 || s_fail !== 1'b0 || s_err !== 16'd0) begin
            errors++;
            $display("FAIL small_done@67: got done=%b pass=%b fail=%b err=%0d want 1 1 0 0",
                     s_done, s_pass, s_fail, s_err);
        end
    endtask

    task automatic test_fault_timing();
        // address 0x3C is compared at edge 770 + 1 + 60 = 831
        wait_until(830);
        checks++;
        if (f_fail !== 1'b0 || f_err !== 16'd0) begin
            errors++;
            $display("FAIL fault_pre: got fail=%b err=%0d want 0 0", f_fail, f_err);
        end
        wait_until(831);
        checks++;
        if (f_fail !== 1'b1 || f_err !== 16'd1 || f_ffa !== 8'h3C || f_done !== 1'b0) begin
            errors++;
            $display("FAIL fault_hit: got fail=%b err=%0d addr=%h done=%b want 1 1 3c 0",
                     f_fail, f_err, f_ffa, f_done);
        end
    endtask

    task automatic test_pass();
        wait_until(1026);
        checks++;
        if (d_done !== 1'b0 || d_pass !== 1'b0) begin
            errors++;
            $display("FAIL done@1026: got done=%b pass=%b want 0 0", d_done, d_pass);
        end
        wait_until(1027);
        checks++;
        if (d_done !== 1'b1 || d_pass !== 1'b1 || d_fail !== 1'b0 || d_err !== 16'd0 ||
            d_ffa !== 8'h00) begin
            errors++;
            $display("FAIL done@1027: got done=%b pass=%b fail=%b err=%0d addr=%h want 1 1 0 0 00",
                     d_done, d_pass, d_fail, d_err, d_ffa);
        end
    endtask

    task automatic test_fault_final();
        checks++;
        if (f_done !== 1'b1 || f_pass !== 1'b0 || f_fail !== 1'b1 || f_err !== 16'd1 ||
            f_ffa !== 8'h3C) begin
            errors++;
            $display("FAIL fault_done: got done=%b pass=%b fail=%b err=%0d addr=%h want 1 0 1 1 3c",
                     f_done, f_pass, f_fail, f_err, f_ffa);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            wait_edges(1000);
            checks++;
            if ({d_done, d_pass, d_fail, d_err, d_ffa} !== {1'b1, 1'b1, 1'b0, 16'd0, 8'h00} ||
                {f_done, f_pass, f_fail, f_err, f_ffa} !== {1'b1, 1'b0, 1'b1, 16'd1, 8'h3C} ||
                {s_done, s_pass, s_fail} !== 3'b110) begin
                errors++;
                $display("FAIL hold_%0d: got dut=%b%b%b/%0d flt=%b%b%b/%0d/%h sml=%b%b%b",
                         i, d_done, d_pass, d_fail, d_err, f_done, f_pass, f_fail, f_err, f_ffa,
                         s_done, s_pass, s_fail);
            end
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        wait_edges(2);
        release_reset();
        wait_until(389);
        checks++;
        if (d_hb !== 1'b1) begin
            errors++;
            $display("FAIL hb@389: got %b want 1", d_hb);
        end
        wait_until(399);
        checks++;
        if (s_done !== 1'b1 || d_done !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset: got sml_done=%b dut_done=%b want 1 0", s_done, d_done);
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_edges(1);
            checks++;
            if (s_done !== 1'b0 || s_pass !== 1'b0 || d_hb !== 1'b0 || d_done !== 1'b0 ||
                f_err !== 16'd0 || f_fail !== 1'b0) begin
                errors++;
                $display("FAIL in_reset_%0d: got sml=%b%b hb=%b done=%b ferr=%0d ffail=%b want 0",
                         i, s_done, s_pass, d_hb, d_done, f_err, f_fail);
            end
        end
        release_reset();
        wait_until(9);
        checks++;
        if (d_hb !== 1'b1) begin
            errors++;
            $display("FAIL hb_restart@9: got %b want 1", d_hb);
        end
        wait_until(1026);
        checks++;
        if (d_done !== 1'b0 || f_fail !== 1'b1) begin
            errors++;
            $display("FAIL restart@1026: got done=%b ffail=%b want 0 1", d_done, f_fail);
        end
        wait_until(1027);
        checks++;
        if (d_done !== 1'b1 || d_pass !== 1'b1 || f_done !== 1'b1 || f_ffa !== 8'h3C ||
            f_err !== 16'd1) begin
            errors++;
            $display("FAIL restart@1027: got done=%b pass=%b fdone=%b faddr=%h ferr=%0d want 1 1 1 3c 1",
                     d_done, d_pass, f_done, f_ffa, f_err);
        end
    endtask

    initial begin
        test_reset();
        test_heartbeat();
        test_small();
        test_fault_timing();
        test_pass();
        test_fault_final();
        test_hold();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
